xbar_port_router: RTL and testbench

XBAR_PORT_ROUTER -- requirements
Module: xbar_port_router

---
 rtl/xbar_pkg.sv | 17 +
 rtl/xbar_port_router_if.sv | 29 ++
 rtl/xbar_ord_fifo.sv | 69 ++++++
 rtl/xbar_port_router.sv | 161 ++++++++++++++++
 tb/tb_xbar_port_router.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xbar_pkg.sv
// Shared types for the crossbar port router.
//   cmd_e   : master command encoding (read / write)
//   state_e : forwarding FSM states
package xbar_pkg;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/xbar_port_router_if.sv
// Master-side request/response bus of the crossbar port router.
//   req/cmd/addr/wdata : request from the master (cmd 0 = read, 1 = write)
//   ack                : one-cycle request-accept pulse
//   resp/rdata         : one-cycle read-data-valid pulse and its data
// Modports: master (request issuer), slave (the router).
interface xbar_port_router_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
);

  logic              req;
  logic              cmd;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic              ack;
  logic              resp;
  logic [DWIDTH-1:0] rdata;

  modport master (
    output req, cmd, addr, wdata,
    input  ack, resp, rdata
  );

  modport slave (
    input  req, cmd, addr, wdata,
    output ack, resp, rdata
  );

endinterface

// File: rtl/xbar_ord_fifo.sv
// In-order FIFO of slave indices for outstanding reads.
//   aclk, aresetn   : clock, synchronous active-low reset (empties the FIFO)
//   push, push_data : enqueue a slave index (ignored when full)
//   pop             : dequeue the head entry (ignored when empty)
//   head            : oldest entry
//   full, empty     : occupancy flags
//   count           : number of entries, $clog2(DEPTH)+1 bits
module xbar_ord_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge aclk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/xbar_port_router.sv
// Routes single master requests to one of SLAVE_NUM slaves by the top address
// bits and returns read data in request order.
//   aclk, aresetn       : clock, synchronous active-low reset
//   m                   : master bus (xbar_port_router_if.slave)
//   s_req/s_cmd         : per-slave request and command
//   s_addr/s_wdata      : shared address/write data, qualified by s_req[i]
//   s_ack/s_resp        : per-slave accept and read-response pulses
//   s_rdata             : packed per-slave read data
//   rd_full             : read-order FIFO full
//   resp_drop           : pulse when a response is unexpected and discarded
module xbar_port_router
  import xbar_pkg::*;
#(
  parameter int unsigned AWIDTH      = 32,
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned SLAVE_NUM   = 4,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  xbar_port_router_if.slave           m,
  output logic [SLAVE_NUM-1:0]        s_req,
  output logic [SLAVE_NUM-1:0]        s_cmd,
  output logic [AWIDTH-1:0]           s_addr,
  output logic [DWIDTH-1:0]           s_wdata,
  input  logic [SLAVE_NUM-1:0]        s_ack,
  input  logic [SLAVE_NUM-1:0]        s_resp,
  input  logic [SLAVE_NUM*DWIDTH-1:0] s_rdata,
  output logic                        rd_full,
  output logic                        resp_drop
);

  localparam int unsigned SW = $clog2(SLAVE_NUM);
  localparam int unsigned CW = $clog2(OUTSTANDING) + 1;

  logic [1:0]           state_q, state_d;
  logic                 cmd_q, cmd_d;
  logic [SW-1:0]        tgt_q, tgt_d, tgt_w;
  logic [SLAVE_NUM-1:0] s_req_q, s_req_d, s_cmd_q, s_cmd_d;
  logic [AWIDTH-1:0]    s_addr_q, s_addr_d;
  logic [DWIDTH-1:0]    s_wdata_q, s_wdata_d;
  logic                 m_ack_q, m_ack_d;
  logic                 m_resp_q;
  logic [DWIDTH-1:0]    m_rdata_q, m_rdata_d;
  logic                 resp_drop_q;

  logic                 push, pop;
  logic [SW-1:0]        fifo_head;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [SLAVE_NUM-1:0] head_oh, stray;
  logic [DWIDTH-1:0]    rdata_arr [SLAVE_NUM];

  assign tgt_w = m.addr[AWIDTH-1 -: SW];

  // Request path: one request in flight, registered towards the slaves.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    tgt_d     = tgt_q;
    s_req_d   = s_req_q;
    s_cmd_d   = s_cmd_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    m_ack_d   = 1'b0;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        // Writes are posted, so only reads need a free order slot.
        if (m.req && (m.cmd == CMD_WRITE || !fifo_full)) begin
          state_d        = FWD;
          cmd_d          = m.cmd;
          tgt_d          = tgt_w;
          s_addr_d       = m.addr;
          s_wdata_d      = m.wdata;
          s_req_d        = '0;
          s_req_d[tgt_w] = 1'b1;
          s_cmd_d        = '0;
          s_cmd_d[tgt_w] = m.cmd;
        end
      end
      FWD: begin
        if (s_ack[tgt_q]) begin
          state_d = ACK;
          s_req_d = '0;
          s_cmd_d = '0;
          m_ack_d = 1'b1;
          push    = (cmd_q == CMD_READ);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response path: only the head slave may answer; anything else is dropped.
  always_comb begin
    for (int i = 0; i < SLAVE_NUM; i++) begin
      rdata_arr[i] = s_rdata[i*DWIDTH +: DWIDTH];
    end
    head_oh = '0;
    if (!fifo_empty) head_oh[fifo_head] = 1'b1;
    pop       = |(s_resp & head_oh);
    stray     = s_resp & ~head_oh;
    m_rdata_d = pop ? rdata_arr[fifo_head] : m_rdata_q;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cmd_q       <= 1'b0;
      tgt_q       <= '0;
      s_req_q     <= '0;
      s_cmd_q     <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      m_ack_q     <= 1'b0;
      m_resp_q    <= 1'b0;
      m_rdata_q   <= '0;
      resp_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      tgt_q       <= tgt_d;
      s_req_q     <= s_req_d;
      s_cmd_q     <= s_cmd_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      m_ack_q     <= m_ack_d;
      m_resp_q    <= pop;
      m_rdata_q   <= m_rdata_d;
      resp_drop_q <= |stray;
    end
  end

  xbar_ord_fifo #(
    .WIDTH (SW),
    .DEPTH (OUTSTANDING)
  ) u_ord_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (push),
    .push_data (tgt_q),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m.ack     = m_ack_q;
  assign m.resp    = m_resp_q;
  assign m.rdata   = m_rdata_q;
  assign s_req     = s_req_q;
  assign s_cmd     = s_cmd_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign rd_full   = (fifo_count == CW'(OUTSTANDING));
  assign resp_drop = resp_drop_q;

endmodule

// File: tb/tb_xbar_port_router.sv
// Directed bench for xbar_port_router (SLAVE_NUM=4, OUTSTANDING=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_xbar_port_router;

  logic         aclk;
  logic         aresetn;
  logic [3:0]   s_req, s_cmd, s_ack, s_resp;
  logic [31:0]  s_addr, s_wdata;
  logic [127:0] s_rdata;
  logic         rd_full, resp_drop;

  int unsigned total_cnt = 0;
  int unsigned pass_cnt  = 0;
  int unsigned fail_cnt  = 0;

  xbar_port_router_if #(.AWIDTH(32), .DWIDTH(32)) m_if ();

  xbar_port_router #(
    .AWIDTH      (32),
    .DWIDTH      (32),
    .SLAVE_NUM   (4),
    .OUTSTANDING (4)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .m         (m_if),
    .s_req     (s_req),
    .s_cmd     (s_cmd),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_ack     (s_ack),
    .s_resp    (s_resp),
    .s_rdata   (s_rdata),
    .rd_full   (rd_full),
    .resp_drop (resp_drop)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, ack it on the cycle s_req appears, and return to idle.
  task automatic xact(input string tag, input logic cmd, input logic [31:0] addr,
                      input logic [3:0] exp_oh);
    m_if.req   = 1'b1;
    m_if.cmd   = cmd;
    m_if.addr  = addr;
    m_if.wdata = 32'h0;
    step();
    check({tag, "_sreq"}, 64'(s_req), 64'(exp_oh));
    s_ack = exp_oh;
    step();
    check({tag, "_mack"}, 64'(m_if.ack), 64'd1);
    s_ack    = 4'b0;
    m_if.req = 1'b0;
    step();
  endtask

  initial begin
    aresetn    = 1'b0;
    m_if.req   = 1'b0;
    m_if.cmd   = 1'b0;
    m_if.addr  = '0;
    m_if.wdata = '0;
    s_ack      = '0;
    s_resp     = '0;
    s_rdata    = '0;
    step();
    step();

    // Reset state
    check("rst_sreq", 64'(s_req), 64'd0);
    check("rst_mack", 64'(m_if.ack), 64'd0);
    check("rst_mresp", 64'(m_if.resp), 64'd0);
    check("rst_mrdata", 64'(m_if.rdata), 64'd0);
    check("rst_rdfull", 64'(rd_full), 64'd0);
    check("rst_drop", 64'(resp_drop), 64'd0);
    aresetn = 1'b1;
    step();

    // Posted write to slave 2, ack at cycle 3 -> m_ack at cycle 4 only
    m_if.req   = 1'b1;
    m_if.cmd   = 1'b1;
    m_if.addr  = 32'h8000_0010;
    m_if.wdata = 32'hDEAD_BEEF;
    step();
    check("wr_c1_sreq", 64'(s_req), 64'h4);
    check("wr_c1_scmd", 64'(s_cmd), 64'h4);
    check("wr_c1_saddr", 64'(s_addr), 64'h8000_0010);
    check("wr_c1_swdata", 64'(s_wdata), 64'hDEAD_BEEF);
    check("wr_c1_mack", 64'(m_if.ack), 64'd0);
    step();
    check("wr_c2_sreq", 64'(s_req), 64'h4);
    step();
    check("wr_c3_sreq", 64'(s_req), 64'h4);
    check("wr_c3_mack", 64'(m_if.ack), 64'd0);
    s_ack = 4'b0100;
    step();
    check("wr_c4_mack", 64'(m_if.ack), 64'd1);
    check("wr_c4_sreq", 64'(s_req), 64'd0);
    s_ack    = 4'b0;
    m_if.req = 1'b0;
    step();
    check("wr_c5_mack", 64'(m_if.ack), 64'd0);
    check("wr_c5_mresp", 64'(m_if.resp), 64'd0);
    check("wr_count", 64'(dut.fifo_count), 64'd0);

    // Ordered reads to slaves 1, 3, 0
    xact("rd1", 1'b0, 32'h4000_0000, 4'b0010);
    check("rd1_scmd", 64'(s_cmd), 64'd0);
    xact("rd3", 1'b0, 32'hC000_0000, 4'b1000);
    xact("rd0", 1'b0, 32'h0000_0000, 4'b0001);
    check("rd_count3", 64'(dut.fifo_count), 64'd3);
    check("rd_full3", 64'(rd_full), 64'd0);
    s_resp = 4'b0010;
    s_rdata[1*32 +: 32] = 32'h11;
    step();
    check("rsp1_mresp", 64'(m_if.resp), 64'd1);
    check("rsp1_rdata", 64'(m_if.rdata), 64'h11);
    s_resp = 4'b1000;
    s_rdata[3*32 +: 32] = 32'h33;
    step();
    check("rsp3_mresp", 64'(m_if.resp), 64'd1);
    check("rsp3_rdata", 64'(m_if.rdata), 64'h33);
    s_resp = 4'b0001;
    s_rdata[0*32 +: 32] = 32'h00;
    step();
    check("rsp0_mresp", 64'(m_if.resp), 64'd1);
    check("rsp0_rdata", 64'(m_if.rdata), 64'h00);
    check("rsp_nodrop", 64'(resp_drop), 64'd0);
    s_resp = 4'b0;
    step();
    check("rsp_idle_mresp", 64'(m_if.resp), 64'd0);
    check("rsp_hold_rdata", 64'(m_if.rdata), 64'h00);
    check("rsp_count0", 64'(dut.fifo_count), 64'd0);

    // Simultaneous push and pop at count 3
    xact("pp0", 1'b0, 32'h0000_0000, 4'b0001);
    xact("pp1", 1'b0, 32'h4000_0000, 4'b0010);
    xact("pp2", 1'b0, 32'h8000_0000, 4'b0100);
    check("pp_count3", 64'(dut.fifo_count), 64'd3);
    m_if.req  = 1'b1;
    m_if.cmd  = 1'b0;
    m_if.addr = 32'hC000_0000;
    step();
    check("pp_sreq", 64'(s_req), 64'h8);
    s_ack  = 4'b1000;
    s_resp = 4'b0001;
    s_rdata[0*32 +: 32] = 32'hA0;
    step();
    check("pp_mack", 64'(m_if.ack), 64'd1);
    check("pp_mresp", 64'(m_if.resp), 64'd1);
    check("pp_rdata", 64'(m_if.rdata), 64'hA0);
    check("pp_count", 64'(dut.fifo_count), 64'd3);
    check("pp_rdfull", 64'(rd_full), 64'd0);
    s_ack    = 4'b0;
    s_resp   = 4'b0;
    m_if.req = 1'b0;
    step();

    // Out-of-order response: head is slave 1, slave 2 answers
    s_resp = 4'b0100;
    step();
    check("ooo_drop", 64'(resp_drop), 64'd1);
    check("ooo_mresp", 64'(m_if.resp), 64'd0);
    check("ooo_count", 64'(dut.fifo_count), 64'd3);
    check("ooo_rdata", 64'(m_if.rdata), 64'hA0);
    s_resp = 4'b0;
    step();
    check("ooo_drop_end", 64'(resp_drop), 64'd0);

    // Full stall and release
    xact("fs0", 1'b0, 32'h0000_0000, 4'b0001);
    check("fs_rdfull", 64'(rd_full), 64'd1);
    m_if.req  = 1'b1;
    m_if.cmd  = 1'b0;
    m_if.addr = 32'h8000_0000;
    step();
    check("fs_stall1_sreq", 64'(s_req), 64'd0);
    step();
    check("fs_stall2_sreq", 64'(s_req), 64'd0);
    check("fs_stall2_mack", 64'(m_if.ack), 64'd0);
    s_resp = 4'b0010;
    s_rdata[1*32 +: 32] = 32'h1111;
    step();
    check("fs_pop_mresp", 64'(m_if.resp), 64'd1);
    check("fs_pop_rdata", 64'(m_if.rdata), 64'h1111);
    check("fs_pop_rdfull", 64'(rd_full), 64'd0);
    s_resp = 4'b0;
    step();
    check("fs_fwd_sreq", 64'(s_req), 64'h4);
    s_ack = 4'b0100;
    step();
    check("fs_fwd_mack", 64'(m_if.ack), 64'd1);
    s_ack    = 4'b0;
    m_if.req = 1'b0;
    step();
    check("fs_refull", 64'(rd_full), 64'd1);

    // Drain to two outstanding (heads 2 then 3), then reset during FWD
    s_resp = 4'b0100;
    s_rdata[2*32 +: 32] = 32'h22;
    step();
    check("dr2_rdata", 64'(m_if.rdata), 64'h22);
    s_resp = 4'b1000;
    s_rdata[3*32 +: 32] = 32'h33;
    step();
    check("dr3_rdata", 64'(m_if.rdata), 64'h33);
    s_resp = 4'b0;
    step();
    check("dr_count2", 64'(dut.fifo_count), 64'd2);
    m_if.req   = 1'b1;
    m_if.cmd   = 1'b1;
    m_if.addr  = 32'h4000_0004;
    m_if.wdata = 32'h5555_AAAA;
    step();
    check("mr_fwd_sreq", 64'(s_req), 64'h2);
    aresetn  = 1'b0;
    m_if.req = 1'b0;
    step();
    check("mr_sreq", 64'(s_req), 64'd0);
    check("mr_scmd", 64'(s_cmd), 64'd0);
    check("mr_saddr", 64'(s_addr), 64'd0);
    check("mr_swdata", 64'(s_wdata), 64'd0);
    check("mr_mack", 64'(m_if.ack), 64'd0);
    check("mr_mresp", 64'(m_if.resp), 64'd0);
    check("mr_mrdata", 64'(m_if.rdata), 64'd0);
    check("mr_rdfull", 64'(rd_full), 64'd0);
    check("mr_count", 64'(dut.fifo_count), 64'd0);
    aresetn = 1'b1;
    s_resp  = 4'b0001;
    step();
    check("late_drop", 64'(resp_drop), 64'd1);
    check("late_mresp", 64'(m_if.resp), 64'd0);
    s_resp = 4'b0;
    step();
    check("late_drop_end", 64'(resp_drop), 64'd0);
    check("late_sreq", 64'(s_req), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
